// File: rtl/histogram_engine_param.sv
// histogram_engine_param
// Streaming histogram accumulator. Packed pixel beats arrive over a
// valid/ready stream. Each pixel is binned into a saturating counter. The
// counters are packed BINS_PER_WORD to a scratch-memory word and updated by a
// three-stage read-modify-write pipeline:
//   S0 - the read address is on the bus.
//   S1 - the freshest copy of the word is chosen and one lane is incremented.
//   S2 - the write is presented.
// Writes that are still in flight are forwarded back into S1, so a run of
// pixels that hit the same word counts exactly. A per-word init bit lets a
// fresh frame treat never-written words as zero without clearing the memory.

module histogram_engine_param #(
  parameter int PIX_W           = 8,
  parameter int PIXELS_PER_BEAT = 16,
  parameter int BINS_PER_WORD   = 4,
  parameter int COUNT_W         = 32,
  parameter int ADDR_W          = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                mode_accumulate,
  input  logic [31:0]                         frame_pixels,
  input  logic                                pix_valid,
  output logic                                pix_ready,
  input  logic [PIXELS_PER_BEAT*PIX_W-1:0]    pix_data,
  output logic [ADDR_W-1:0]                   scratch_memory_address_pointer0,
  input  logic [BINS_PER_WORD*COUNT_W-1:0]    scratch_memory_rdata0,
  output logic                                write_enable,
  output logic [ADDR_W-1:0]                   write_address,
  output logic [BINS_PER_WORD*COUNT_W-1:0]    scratch_memory_wdata,
  output logic                                busy,
  output logic                                done,
  output logic                                saturated
);

  localparam int NBINS   = 1 << PIX_W;
  localparam int NWORDS  = NBINS / BINS_PER_WORD;
  localparam int WORD_W  = BINS_PER_WORD * COUNT_W;
  localparam int LANE_IW = (BINS_PER_WORD > 1) ? $clog2(BINS_PER_WORD) : 1;
  localparam int WIDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BIDX_W  = (PIXELS_PER_BEAT > 1) ? $clog2(PIXELS_PER_BEAT) : 1;
  localparam logic [BIDX_W-1:0]  LAST_IDX = BIDX_W'(PIXELS_PER_BEAT - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Word index of a pixel (its bin divided by the number of lanes per word).
  function automatic logic [WIDX_W-1:0] word_of(input logic [PIX_W-1:0] pix);
    return WIDX_W'(int'(pix) / BINS_PER_WORD);
  endfunction

  // Lane of a pixel inside its word; lane 0 is the least significant counter.
  function automatic logic [LANE_IW-1:0] lane_of(input logic [PIX_W-1:0] pix);
    return LANE_IW'(int'(pix) % BINS_PER_WORD);
  endfunction

  // Control and buffer state.
  state_t                             state_q, state_d;
  logic [31:0]                        remaining_q, remaining_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic                               sat_q, sat_d;
  logic                               pix_ready_q, pix_ready_d;
  logic [PIXELS_PER_BEAT*PIX_W-1:0]   buf_q, buf_d;
  logic                               buf_vld_q, buf_vld_d;
  logic [BIDX_W-1:0]                  buf_idx_q, buf_idx_d;

  // Pipeline state.
  logic                               s0_vld_q, s0_vld_d;
  logic [PIX_W-1:0]                   s0_pix_q, s0_pix_d;
  logic [ADDR_W-1:0]                  rd_addr_q, rd_addr_d;
  logic                               s1_vld_q, s1_vld_d;
  logic [PIX_W-1:0]                   s1_pix_q, s1_pix_d;
  logic                               we_q, we_d;
  logic [ADDR_W-1:0]                  waddr_q, waddr_d;
  logic [WORD_W-1:0]                  wdata_q, wdata_d;
  logic                               pwe_q, pwe_d;
  logic [ADDR_W-1:0]                  paddr_q, paddr_d;
  logic [WORD_W-1:0]                  pdata_q, pdata_d;
  logic [NWORDS-1:0]                  init_q, init_d;

  // Combinational helpers.
  logic                               start_acc_s;
  logic                               issue_s;
  logic                               beat_take_s;
  logic [PIX_W-1:0]                   cur_pix_s;
  logic [WIDX_W-1:0]                  s1_word_s;
  logic [LANE_IW-1:0]                 s1_lane_s;
  logic [ADDR_W-1:0]                  s1_addr_s;
  logic [WORD_W-1:0]                  base_s;
  logic [WORD_W-1:0]                  new_word_s;
  logic [COUNT_W-1:0]                 lane_val_s;
  logic                               lane_sat_s;
  logic [NWORDS-1:0]                  init_set_s;

  // Frame FSM, beat buffer and issue stage: next-state logic.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    buf_idx_d   = buf_idx_q;
    s0_vld_d    = 1'b0;
    s0_pix_d    = s0_pix_q;
    rd_addr_d   = rd_addr_q;
    start_acc_s = 1'b0;
    issue_s     = (state_q == ST_RUN) && buf_vld_q;
    beat_take_s = pix_ready_q && pix_valid;
    cur_pix_s   = buf_q[int'(buf_idx_q)*PIX_W +: PIX_W];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          remaining_d = frame_pixels;
          busy_d      = 1'b1;
          if (frame_pixels == 32'd0) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          busy_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (issue_s) begin
          s0_vld_d    = 1'b1;
          s0_pix_d    = cur_pix_s;
          rd_addr_d   = ADDR_W'(word_of(cur_pix_s));
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) begin
            // Last pixel of the frame: drop whatever is left in the beat.
            state_d   = ST_DRAIN;
            buf_vld_d = 1'b0;
            buf_idx_d = {BIDX_W{1'b0}};
          end else if (buf_idx_q == LAST_IDX) begin
            buf_vld_d = 1'b0;
            buf_idx_d = {BIDX_W{1'b0}};
          end else begin
            buf_idx_d = buf_idx_q + BIDX_W'(1);
          end
        end else begin
          s0_vld_d = 1'b0;
        end
        if (beat_take_s) begin
          buf_d     = pix_data;
          buf_vld_d = 1'b1;
          buf_idx_d = {BIDX_W{1'b0}};
        end else begin
          buf_d = buf_q;
        end
      end

      ST_DRAIN: begin
        // S0 empty means the final pixel is in S1 and its write goes out
        // together with the done pulse.
        if (!s0_vld_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          done_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Accept a beat only when it will be consumed: the buffer is empty, or its
    // last pixel issues next cycle and the frame still wants more pixels.
    pix_ready_d = (state_d == ST_RUN) &&
                  (!buf_vld_d || ((buf_idx_d == LAST_IDX) && (remaining_d != 32'd1)));
  end

  // Modify stage: pick the freshest copy of the word and bump one lane.
  always_comb begin
    s1_word_s = word_of(s1_pix_q);
    s1_lane_s = lane_of(s1_pix_q);
    s1_addr_s = ADDR_W'(s1_word_s);
    if (we_q && (waddr_q == s1_addr_s)) begin
      base_s = wdata_q;
    end else if (pwe_q && (paddr_q == s1_addr_s)) begin
      base_s = pdata_q;
    end else if (init_q[s1_word_s]) begin
      base_s = scratch_memory_rdata0;
    end else begin
      base_s = {WORD_W{1'b0}};
    end
    lane_val_s = base_s[int'(s1_lane_s)*COUNT_W +: COUNT_W];
    new_word_s = base_s;
    if (lane_val_s == CNT_MAX) begin
      lane_sat_s = 1'b1;
    end else begin
      lane_sat_s = 1'b0;
      new_word_s[int'(s1_lane_s)*COUNT_W +: COUNT_W] = lane_val_s + COUNT_W'(1);
    end
  end

  // Pipeline advance, write stage, init tracking and sticky saturation flag.
  always_comb begin
    s1_vld_d = s0_vld_q;
    s1_pix_d = s0_pix_q;
    pwe_d    = we_q;
    paddr_d  = waddr_q;
    pdata_d  = wdata_q;
    we_d     = s1_vld_q;
    init_set_s = {NWORDS{1'b0}};
    if (s1_vld_q) begin
      waddr_d = s1_addr_s;
      wdata_d = new_word_s;
      init_set_s[s1_word_s] = 1'b1;
    end else begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end
    if (start_acc_s && !mode_accumulate) begin
      init_d = init_set_s;
    end else begin
      init_d = init_q | init_set_s;
    end
    if (start_acc_s) begin
      sat_d = 1'b0;
    end else if (s1_vld_q && lane_sat_s) begin
      sat_d = 1'b1;
    end else begin
      sat_d = sat_q;
    end
  end

  // State registers with synchronous reset; reset also aborts any frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
      pix_ready_q <= 1'b0;
      buf_q       <= {(PIXELS_PER_BEAT*PIX_W){1'b0}};
      buf_vld_q   <= 1'b0;
      buf_idx_q   <= {BIDX_W{1'b0}};
      s0_vld_q    <= 1'b0;
      s0_pix_q    <= {PIX_W{1'b0}};
      rd_addr_q   <= {ADDR_W{1'b0}};
      s1_vld_q    <= 1'b0;
      s1_pix_q    <= {PIX_W{1'b0}};
      we_q        <= 1'b0;
      waddr_q     <= {ADDR_W{1'b0}};
      wdata_q     <= {WORD_W{1'b0}};
      pwe_q       <= 1'b0;
      paddr_q     <= {ADDR_W{1'b0}};
      pdata_q     <= {WORD_W{1'b0}};
      init_q      <= {NWORDS{1'b0}};
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
      pix_ready_q <= pix_ready_d;
      buf_q       <= buf_d;
      buf_vld_q   <= buf_vld_d;
      buf_idx_q   <= buf_idx_d;
      s0_vld_q    <= s0_vld_d;
      s0_pix_q    <= s0_pix_d;
      rd_addr_q   <= rd_addr_d;
      s1_vld_q    <= s1_vld_d;
      s1_pix_q    <= s1_pix_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      pwe_q       <= pwe_d;
      paddr_q     <= paddr_d;
      pdata_q     <= pdata_d;
      init_q      <= init_d;
    end
  end

  assign pix_ready                       = pix_ready_q;
  assign scratch_memory_address_pointer0 = rd_addr_q;
  assign write_enable                    = we_q;
  assign write_address                   = waddr_q;
  assign scratch_memory_wdata            = wdata_q;
  assign busy                            = busy_q;
  assign done                            = done_q;
  assign saturated                       = sat_q;

endmodule
